// File: rtl/bp_jtag_write_arbiter_pkg.sv
// Shared types for the JTAG player FIFO write arbiter: FSM encoding, requester ids, grant masks.
package bp_jtag_write_arbiter_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BCNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

    localparam logic REQ_RBCP   = 1'b0;
    localparam logic REQ_STREAM = 1'b1;

    localparam logic [1:0] GNT_NONE   = 2'b00;
    localparam logic [1:0] GNT_RBCP   = 2'b01;
    localparam logic [1:0] GNT_STREAM = 2'b10;

    typedef struct packed {
        logic              valid;
        logic              last;
        logic [BYTE_W-1:0] data;
    } req_beat_t;

    function automatic logic [1:0] gnt_mask(input logic owner);
        return (owner == REQ_STREAM) ? GNT_STREAM : GNT_RBCP;
    endfunction

endpackage

// File: rtl/bp_jtag_write_arbiter_if.sv
// Requester and FIFO write-port signals of the JTAG write arbiter.
interface bp_jtag_write_arbiter_if;
    import bp_jtag_write_arbiter_pkg::*;

    logic              REQ0_VALID;
    logic [BYTE_W-1:0] REQ0_DATA;
    logic              REQ0_LAST;
    logic              REQ0_READY;
    logic              REQ1_VALID;
    logic [BYTE_W-1:0] REQ1_DATA;
    logic              REQ1_LAST;
    logic              REQ1_READY;
    logic              FIFO_FULL;
    logic              FIFO_ERR;
    logic              FIFO_WE;
    logic [BYTE_W-1:0] FIFO_DATA;

    // Arbiter side: accepts requests, drives the FIFO write port.
    modport master (
        input  REQ0_VALID, REQ0_DATA, REQ0_LAST, REQ1_VALID, REQ1_DATA, REQ1_LAST,
        input  FIFO_FULL, FIFO_ERR,
        output REQ0_READY, REQ1_READY, FIFO_WE, FIFO_DATA
    );

    // Requester / FIFO side.
    modport slave (
        output REQ0_VALID, REQ0_DATA, REQ0_LAST, REQ1_VALID, REQ1_DATA, REQ1_LAST,
        output FIFO_FULL, FIFO_ERR,
        input  REQ0_READY, REQ1_READY, FIFO_WE, FIFO_DATA
    );

endinterface

// File: rtl/bp_slow_clk_gen.sv
// Divides CLK_133m into the slow FIFO clock and marks phase 0 as the write slot.
module bp_slow_clk_gen #(
    parameter int unsigned DIV_HALF = 2
) (
    input  logic CLK_133m,
    input  logic RST,
    output logic slow_clk,
    output logic slot_c
);

    localparam int unsigned PERIOD = 2 * DIV_HALF;
    localparam int unsigned PH_W   = $clog2(PERIOD);

    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_nxt;

    always_comb begin
        ph_nxt = (ph == PH_W'(PERIOD - 1)) ? '0 : PH_W'(ph + PH_W'(1));
    end

    // slow_clk tracks the phase it will be in, so it is high exactly for phases >= DIV_HALF
    always_ff @(posedge CLK_133m or posedge RST) begin
        if (RST) begin
            ph       <= '0;
            slow_clk <= 1'b0;
        end else begin
            ph       <= ph_nxt;
            slow_clk <= (ph_nxt >= PH_W'(DIV_HALF));
        end
    end

    assign slot_c = (ph == '0);

endmodule

// File: rtl/bp_jtag_write_arbiter.sv
// Round-robin, burst-locked arbiter for the JTAG player FIFO write port (RBCP vs. bitstream).
// Optional statistics counters are built when BP_JTAG_ARB_STATS_EN is defined.
module bp_jtag_write_arbiter
    import bp_jtag_write_arbiter_pkg::*;
#(
    parameter int unsigned DIV_HALF  = 2,
    parameter int unsigned BURST_MAX = 16,
    parameter int unsigned CNT_W     = 24
) (
    input  logic                     CLK_133m,
    input  logic                     RST,
    output logic                     SLOW_CLK,
    bp_jtag_write_arbiter_if.master  bus,
    input  logic                     ABORT,
    input  logic                     ERR_CLR,
    output logic [1:0]               GNT,
    output logic                     BUSY,
    output logic                     ERR_FLAG,
    output logic [CNT_W-1:0]         STAT_BYTES0,
    output logic [CNT_W-1:0]         STAT_BYTES1,
    output logic [CNT_W-1:0]         STAT_STALL
);

    logic slot_c;

    bp_slow_clk_gen #(.DIV_HALF(DIV_HALF)) u_slow_clk (
        .CLK_133m (CLK_133m),
        .RST      (RST),
        .slow_clk (SLOW_CLK),
        .slot_c   (slot_c)
    );

    arb_state_e        st_q, st_nxt;
    logic              owner_q, owner_nxt;
    logic              last_owner_q, last_owner_nxt;
    logic              fin_q, fin_nxt;
    logic              abort_q, abort_nxt;
    logic              err_nxt;
    logic [BCNT_W-1:0] bcnt_q, bcnt_nxt, bcnt_base;
    logic              we_q, we_nxt;
    logic [BYTE_W-1:0] data_q, data_nxt;
    logic              rdy0_q, rdy0_nxt, rdy1_q, rdy1_nxt;
    logic [1:0]        gnt_nxt;
    logic              sel;
    logic              try_c;
    req_beat_t         beat0, beat1, beat;

    assign beat0 = '{valid: bus.REQ0_VALID, last: bus.REQ0_LAST, data: bus.REQ0_DATA};
    assign beat1 = '{valid: bus.REQ1_VALID, last: bus.REQ1_LAST, data: bus.REQ1_DATA};

    // Next-state: every grant/launch decision is taken on the slot cycle only.
    always_comb begin
        st_nxt         = st_q;
        owner_nxt      = owner_q;
        last_owner_nxt = last_owner_q;
        fin_nxt        = fin_q;
        bcnt_nxt       = bcnt_q;
        we_nxt         = we_q;
        data_nxt       = data_q;
        rdy0_nxt       = 1'b0;
        rdy1_nxt       = 1'b0;
        abort_nxt      = abort_q | ABORT;
        err_nxt        = bus.FIFO_ERR | ABORT | (ERR_FLAG & ~ERR_CLR);
        sel            = owner_q;
        bcnt_base      = bcnt_q;
        try_c          = 1'b0;
        beat           = beat0;

        if (slot_c) begin
            we_nxt = 1'b0;
            if (abort_q || ABORT) begin
                st_nxt    = ST_IDLE;
                fin_nxt   = 1'b0;
                bcnt_nxt  = '0;
                abort_nxt = 1'b0;
            end else begin
                case (st_q)
                    ST_IDLE: begin
                        if (beat0.valid || beat1.valid) begin
                            sel       = (beat0.valid && beat1.valid) ? ~last_owner_q : beat1.valid;
                            owner_nxt = sel;
                            bcnt_base = '0;
                            try_c     = 1'b1;
                        end
                    end
                    ST_XFER: begin
                        // Finished burst keeps its grant for one slow period, then releases
                        if (fin_q) begin
                            st_nxt   = ST_IDLE;
                            fin_nxt  = 1'b0;
                            bcnt_nxt = '0;
                        end else begin
                            try_c = 1'b1;
                        end
                    end
                    ST_HOLD: try_c = 1'b1;
                    default: st_nxt = ST_IDLE;
                endcase

                if (try_c) begin
                    beat     = sel ? beat1 : beat0;
                    bcnt_nxt = bcnt_base;
                    st_nxt   = ST_XFER;
                    if (bus.FIFO_FULL) begin
                        st_nxt = ST_HOLD;
                    end else if (beat.valid) begin
                        we_nxt   = 1'b1;
                        data_nxt = beat.data;
                        rdy0_nxt = (sel == REQ_RBCP);
                        rdy1_nxt = (sel == REQ_STREAM);
                        bcnt_nxt = BCNT_W'(bcnt_base + 1'b1);
                        if (beat.last || (bcnt_nxt == BCNT_W'(BURST_MAX))) begin
                            fin_nxt        = 1'b1;
                            last_owner_nxt = sel;
                        end
                    end
                end
            end
        end

        gnt_nxt = (st_nxt == ST_IDLE) ? GNT_NONE : gnt_mask(owner_nxt);
    end

    always_ff @(posedge CLK_133m or posedge RST) begin
        if (RST) begin
            st_q         <= ST_IDLE;
            owner_q      <= REQ_RBCP;
            last_owner_q <= REQ_STREAM;
            fin_q        <= 1'b0;
            abort_q      <= 1'b0;
            bcnt_q       <= '0;
            we_q         <= 1'b0;
            data_q       <= '0;
            rdy0_q       <= 1'b0;
            rdy1_q       <= 1'b0;
            GNT          <= GNT_NONE;
            BUSY         <= 1'b0;
            ERR_FLAG     <= 1'b0;
        end else begin
            st_q         <= st_nxt;
            owner_q      <= owner_nxt;
            last_owner_q <= last_owner_nxt;
            fin_q        <= fin_nxt;
            abort_q      <= abort_nxt;
            bcnt_q       <= bcnt_nxt;
            we_q         <= we_nxt;
            data_q       <= data_nxt;
            rdy0_q       <= rdy0_nxt;
            rdy1_q       <= rdy1_nxt;
            GNT          <= gnt_nxt;
            BUSY         <= (st_nxt != ST_IDLE);
            ERR_FLAG     <= err_nxt;
        end
    end

    assign bus.FIFO_WE    = we_q;
    assign bus.FIFO_DATA  = data_q;
    assign bus.REQ0_READY = rdy0_q;
    assign bus.REQ1_READY = rdy1_q;

`ifdef BP_JTAG_ARB_STATS_EN
    logic [CNT_W-1:0] stat_b0_q, stat_b1_q, stat_stall_q;

    // Saturating per-requester byte counts and HOLD-slot count
    always_ff @(posedge CLK_133m or posedge RST) begin
        if (RST) begin
            stat_b0_q    <= '0;
            stat_b1_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            if (rdy0_nxt && (stat_b0_q != '1)) stat_b0_q <= CNT_W'(stat_b0_q + 1'b1);
            if (rdy1_nxt && (stat_b1_q != '1)) stat_b1_q <= CNT_W'(stat_b1_q + 1'b1);
            if (slot_c && (st_q == ST_HOLD) && (stat_stall_q != '1))
                stat_stall_q <= CNT_W'(stat_stall_q + 1'b1);
        end
    end

    assign STAT_BYTES0 = stat_b0_q;
    assign STAT_BYTES1 = stat_b1_q;
    assign STAT_STALL  = stat_stall_q;
`else
    assign STAT_BYTES0 = '0;
    assign STAT_BYTES1 = '0;
    assign STAT_STALL  = '0;
`endif

endmodule

// File: tb/tb_bp_jtag_write_arbiter.sv
// Directed bench for bp_jtag_write_arbiter; stats expectations follow BP_JTAG_ARB_STATS_EN.
module tb_bp_jtag_write_arbiter;

    logic        CLK_133m = 1'b0;
    logic        RST;
    logic        SLOW_CLK;
    logic        ABORT;
    logic        ERR_CLR;
    logic [1:0]  GNT;
    logic        BUSY;
    logic        ERR_FLAG;
    logic [23:0] STAT_BYTES0, STAT_BYTES1, STAT_STALL;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] wr_q[$];

    always #5 CLK_133m = ~CLK_133m;

    bp_jtag_write_arbiter_if bus();

    bp_jtag_write_arbiter #(.DIV_HALF(2), .BURST_MAX(16), .CNT_W(24)) u_dut (
        .CLK_133m    (CLK_133m),
        .RST         (RST),
        .SLOW_CLK    (SLOW_CLK),
        .bus         (bus),
        .ABORT       (ABORT),
        .ERR_CLR     (ERR_CLR),
        .GNT         (GNT),
        .BUSY        (BUSY),
        .ERR_FLAG    (ERR_FLAG),
        .STAT_BYTES0 (STAT_BYTES0),
        .STAT_BYTES1 (STAT_BYTES1),
        .STAT_STALL  (STAT_STALL)
    );

    // FIFO model: a byte is written on each slow rising edge with WE high
    always @(posedge SLOW_CLK) if (bus.FIFO_WE) wr_q.push_back(bus.FIFO_DATA);

    task automatic idle_inputs();
        bus.REQ0_VALID = 1'b0; bus.REQ0_DATA = 8'h00; bus.REQ0_LAST = 1'b0;
        bus.REQ1_VALID = 1'b0; bus.REQ1_DATA = 8'h00; bus.REQ1_LAST = 1'b0;
        bus.FIFO_FULL  = 1'b0; bus.FIFO_ERR  = 1'b0;
        ABORT = 1'b0; ERR_CLR = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        RST = 1'b1;
        repeat (3) @(negedge CLK_133m);
        RST = 1'b0;
        wr_q.delete();
    endtask

    task automatic drive_stream(input bit id, input int n, input logic [7:0] base,
                                input bit last_at_end, output int got);
        int cyc;
        got = 0;
        for (int i = 0; i < n; i++) begin
            if (id) begin
                bus.REQ1_VALID = 1'b1; bus.REQ1_DATA = 8'(base + 8'(i));
                bus.REQ1_LAST  = last_at_end && (i == n - 1);
            end else begin
                bus.REQ0_VALID = 1'b1; bus.REQ0_DATA = 8'(base + 8'(i));
                bus.REQ0_LAST  = last_at_end && (i == n - 1);
            end
            cyc = 0;
            do begin
                @(negedge CLK_133m);
                cyc++;
            end while (!(id ? bus.REQ1_READY : bus.REQ0_READY) && cyc < 200);
            if (!(id ? bus.REQ1_READY : bus.REQ0_READY)) begin
                tests_run++; tests_failed++;
                $display("FAIL ready_timeout: req%0d byte %0d got no READY, required one within 200 cycles", id, i);
                break;
            end
            got++;
        end
        if (id) begin bus.REQ1_VALID = 1'b0; bus.REQ1_LAST = 1'b0; end
        else    begin bus.REQ0_VALID = 1'b0; bus.REQ0_LAST = 1'b0; end
    endtask

    task automatic test_reset();
        int ph_bad, rises, highs, idle_bad;
        logic prev;
        idle_inputs();
        RST = 1'b0;
        #2 RST = 1'b1;
        #1;
        tests_run++;
        if ({SLOW_CLK, bus.FIFO_WE, bus.REQ0_READY, bus.REQ1_READY, BUSY, ERR_FLAG} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_scalars: got %b required 000000", {SLOW_CLK, bus.FIFO_WE, bus.REQ0_READY, bus.REQ1_READY, BUSY, ERR_FLAG});
        end
        tests_run++;
        if ({GNT, bus.FIFO_DATA} !== 10'h000) begin
            tests_failed++;
            $display("FAIL reset_gnt_data: got GNT=%b DATA=%h required 00/00", GNT, bus.FIFO_DATA);
        end
        tests_run++;
        if ({STAT_BYTES0, STAT_BYTES1, STAT_STALL} !== 72'h0) begin
            tests_failed++;
            $display("FAIL reset_stats: got %h %h %h required 0", STAT_BYTES0, STAT_BYTES1, STAT_STALL);
        end
        repeat (3) @(negedge CLK_133m);
        RST = 1'b0;
        ph_bad = 0; rises = 0; highs = 0; idle_bad = 0; prev = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge CLK_133m);
            if (SLOW_CLK !== (((k + 1) % 4) >= 2)) ph_bad++;
            if (SLOW_CLK === 1'b1) highs++;
            if (SLOW_CLK === 1'b1 && prev === 1'b0) rises++;
            if (bus.FIFO_WE !== 1'b0 || GNT !== 2'b00 || BUSY !== 1'b0) idle_bad++;
            prev = SLOW_CLK;
        end
        tests_run++;
        if (ph_bad != 0) begin tests_failed++; $display("FAIL slow_clk_phase: got %0d wrong samples required 0", ph_bad); end
        tests_run++;
        if (rises != 16) begin tests_failed++; $display("FAIL slow_clk_period: got %0d rises in 64 cycles required 16", rises); end
        tests_run++;
        if (highs != 32) begin tests_failed++; $display("FAIL slow_clk_duty: got %0d high cycles required 32", highs); end
        tests_run++;
        if (idle_bad != 0) begin tests_failed++; $display("FAIL idle_outputs: got %0d non-idle samples required 0", idle_bad); end
    endtask

    task automatic test_single_byte();
        int we_cnt, bad_data, rdy_cnt;
        bit saw01;
        apply_reset();
        bus.REQ0_VALID = 1'b1; bus.REQ0_DATA = 8'hA5; bus.REQ0_LAST = 1'b1;
        we_cnt = 0; bad_data = 0; rdy_cnt = 0; saw01 = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge CLK_133m);
            if (bus.REQ0_READY === 1'b1) begin rdy_cnt++; bus.REQ0_VALID = 1'b0; bus.REQ0_LAST = 1'b0; end
            if (bus.FIFO_WE === 1'b1) begin we_cnt++; if (bus.FIFO_DATA !== 8'hA5) bad_data++; end
            if (GNT === 2'b01) saw01 = 1'b1;
        end
        tests_run++;
        if (we_cnt != 4) begin tests_failed++; $display("FAIL single_we_len: got %0d cycles required 4", we_cnt); end
        tests_run++;
        if (bad_data != 0) begin tests_failed++; $display("FAIL single_data: got %0d bad samples required 0", bad_data); end
        tests_run++;
        if (rdy_cnt != 1) begin tests_failed++; $display("FAIL single_ready: got %0d pulses required 1", rdy_cnt); end
        tests_run++;
        if (!saw01 || GNT !== 2'b00) begin
            tests_failed++; $display("FAIL single_gnt: got saw01=%0d final=%b required 1/00", saw01, GNT);
        end
        tests_run++;
        if (wr_q.size() != 1 || wr_q[0] !== 8'hA5) begin
            tests_failed++; $display("FAIL single_fifo: got %0d bytes required 1 byte A5", wr_q.size());
        end
    endtask

    task automatic test_round_robin();
        int got0, got1, g01, g10, bad;
        logic [1:0] prev, first;
        logic [7:0] exp_b;
        int exp_s0, exp_s1;
        apply_reset();
        g01 = 0; g10 = 0; prev = 2'b00; first = 2'b00;
        fork
            drive_stream(1'b0, 1, 8'h3C, 1'b1, got0);
            drive_stream(1'b1, 20, 8'h40, 1'b1, got1);
            for (int k = 0; k < 140; k++) begin
                @(negedge CLK_133m);
                if (GNT === 2'b01 && prev !== 2'b01) g01++;
                if (GNT === 2'b10 && prev !== 2'b10) g10++;
                if (first === 2'b00 && GNT !== 2'b00) first = GNT;
                prev = GNT;
            end
        join
        tests_run++;
        if (first !== 2'b01) begin tests_failed++; $display("FAIL rr_first_gnt: got %b required 01", first); end
        tests_run++;
        if (g01 != 1 || g10 != 2) begin
            tests_failed++; $display("FAIL rr_grants: got req0=%0d req1=%0d grants required 1/2", g01, g10);
        end
        bad = 0;
        if (wr_q.size() != 21) bad++;
        else for (int i = 0; i < 21; i++) begin
            exp_b = (i == 0) ? 8'h3C : 8'(8'h40 + 8'(i - 1));
            if (wr_q[i] !== exp_b) bad++;
        end
        tests_run++;
        if (bad != 0 || got0 != 1 || got1 != 20) begin
            tests_failed++; $display("FAIL rr_order: got %0d bytes (%0d bad) ready %0d/%0d required 21 bytes 3C,40..53", wr_q.size(), bad, got0, got1);
        end
`ifdef BP_JTAG_ARB_STATS_EN
        exp_s0 = 1; exp_s1 = 20;
`else
        exp_s0 = 0; exp_s1 = 0;
`endif
        tests_run++;
        if (STAT_BYTES0 !== 24'(exp_s0) || STAT_BYTES1 !== 24'(exp_s1)) begin
            tests_failed++; $display("FAIL rr_stats: got %0d/%0d required %0d/%0d", STAT_BYTES0, STAT_BYTES1, exp_s0, exp_s1);
        end
    endtask

    task automatic test_backpressure();
        int got1, nrdy, we_bad, rdy_bad, bad, exp_stall, exp_b1;
        bit resumed;
        apply_reset();
        nrdy = 0; we_bad = 0; rdy_bad = 0; resumed = 1'b0;
        fork
            drive_stream(1'b1, 6, 8'h80, 1'b1, got1);
            begin
                for (int k = 0; k < 100 && nrdy < 2; k++) begin
                    @(negedge CLK_133m);
                    if (bus.REQ1_READY === 1'b1) nrdy++;
                end
                bus.FIFO_FULL = 1'b1;
                for (int j = 1; j <= 16; j++) begin
                    @(negedge CLK_133m);
                    if (j >= 4 && j <= 15 && bus.FIFO_WE !== 1'b0) we_bad++;
                    if (j <= 15 && bus.REQ1_READY !== 1'b0) rdy_bad++;
                    if (j == 16 && bus.REQ1_READY === 1'b1 && bus.FIFO_DATA === 8'h82) resumed = 1'b1;
                    if (j == 12) bus.FIFO_FULL = 1'b0;
                end
            end
        join
        repeat (12) @(negedge CLK_133m);
        tests_run++;
        if (nrdy != 2 || we_bad != 0 || rdy_bad != 0) begin
            tests_failed++; $display("FAIL full_stall: got pre=%0d we_high=%0d ready=%0d required 2/0/0", nrdy, we_bad, rdy_bad);
        end
        tests_run++;
        if (!resumed) begin tests_failed++; $display("FAIL full_resume: got no byte 82 launch at slot after FULL drop, required one"); end
        bad = 0;
        if (wr_q.size() != 6) bad++;
        else for (int i = 0; i < 6; i++) if (wr_q[i] !== 8'(8'h80 + 8'(i))) bad++;
        tests_run++;
        if (bad != 0 || got1 != 6) begin
            tests_failed++; $display("FAIL full_bytes: got %0d bytes (%0d bad) required 80..85", wr_q.size(), bad);
        end
`ifdef BP_JTAG_ARB_STATS_EN
        exp_stall = 3; exp_b1 = 6;
`else
        exp_stall = 0; exp_b1 = 0;
`endif
        tests_run++;
        if (STAT_STALL !== 24'(exp_stall) || STAT_BYTES1 !== 24'(exp_b1) || STAT_BYTES0 !== 24'h0) begin
            tests_failed++; $display("FAIL full_stats: got stall=%0d b1=%0d b0=%0d required %0d/%0d/0", STAT_STALL, STAT_BYTES1, STAT_BYTES0, exp_stall, exp_b1);
        end
    endtask

    task automatic test_abort();
        int got1, bad;
        apply_reset();
        drive_stream(1'b1, 3, 8'h60, 1'b0, got1);
        bus.REQ1_VALID = 1'b1; bus.REQ1_DATA = 8'h63; bus.REQ1_LAST = 1'b0;
        ABORT = 1'b1;
        @(negedge CLK_133m);
        ABORT = 1'b0;
        tests_run++;
        if (ERR_FLAG !== 1'b1) begin tests_failed++; $display("FAIL abort_errflag: got %b required 1", ERR_FLAG); end
        repeat (3) @(negedge CLK_133m);
        tests_run++;
        if ({bus.FIFO_WE, GNT, BUSY, bus.REQ1_READY} !== 5'b0) begin
            tests_failed++; $display("FAIL abort_release: got WE,GNT,BUSY,RDY=%b required 00000", {bus.FIFO_WE, GNT, BUSY, bus.REQ1_READY});
        end
        bus.REQ1_VALID = 1'b0;
        repeat (8) @(negedge CLK_133m);
        bad = 0;
        if (wr_q.size() != 3) bad++;
        else for (int i = 0; i < 3; i++) if (wr_q[i] !== 8'(8'h60 + 8'(i))) bad++;
        tests_run++;
        if (bad != 0 || got1 != 3) begin tests_failed++; $display("FAIL abort_bytes: got %0d bytes required 60,61,62", wr_q.size()); end
        ERR_CLR = 1'b1;
        @(negedge CLK_133m);
        ERR_CLR = 1'b0;
        tests_run++;
        if (ERR_FLAG !== 1'b0) begin tests_failed++; $display("FAIL err_clr: got %b required 0", ERR_FLAG); end
        ERR_CLR = 1'b1; bus.FIFO_ERR = 1'b1;
        @(negedge CLK_133m);
        ERR_CLR = 1'b0; bus.FIFO_ERR = 1'b0;
        tests_run++;
        if (ERR_FLAG !== 1'b1) begin tests_failed++; $display("FAIL err_set_wins: got %b required 1", ERR_FLAG); end
        @(negedge CLK_133m);
        tests_run++;
        if (ERR_FLAG !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b required 1", ERR_FLAG); end
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        apply_reset();
        bus.FIFO_ERR = 1'b1;
        @(negedge CLK_133m);
        bus.FIFO_ERR = 1'b0;
        bus.REQ1_VALID = 1'b1; bus.REQ1_DATA = 8'h90; bus.REQ1_LAST = 1'b0;
        cyc = 0;
        do begin @(negedge CLK_133m); cyc++; end while (bus.REQ1_READY !== 1'b1 && cyc < 50);
        tests_run++;
        if ({bus.FIFO_WE, ERR_FLAG, GNT} !== 4'b1110) begin
            tests_failed++; $display("FAIL pre_rst_state: got WE,ERR,GNT=%b required 1110", {bus.FIFO_WE, ERR_FLAG, GNT});
        end
        #2 RST = 1'b1;
        #1;
        tests_run++;
        if ({SLOW_CLK, bus.FIFO_WE, bus.REQ1_READY, BUSY, ERR_FLAG, GNT} !== 7'b0 || bus.FIFO_DATA !== 8'h00) begin
            tests_failed++; $display("FAIL async_rst: got SLOW,WE,RDY,BUSY,ERR,GNT=%b DATA=%h required 0/00",
                {SLOW_CLK, bus.FIFO_WE, bus.REQ1_READY, BUSY, ERR_FLAG, GNT}, bus.FIFO_DATA);
        end
        tests_run++;
        if ({STAT_BYTES0, STAT_BYTES1, STAT_STALL} !== 72'h0) begin
            tests_failed++; $display("FAIL async_rst_stats: got %0d %0d %0d required 0", STAT_BYTES0, STAT_BYTES1, STAT_STALL);
        end
        idle_inputs();
        @(negedge CLK_133m);
        RST = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_backpressure();
        test_abort();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
